// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues word reads, buffers responses in order, hands them on.
// Define FETCH_PERF_EN to add stall and flush performance counters.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW:0] CAP = {1'b0, FULL};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;

    logic [63:0]   fetch_pc;
    logic [63:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic [31:0] q_data [DEPTH];
    logic [63:0] q_pc   [DEPTH];

    logic          req_fire;
    logic          redir;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          enq;
    logic          deq;
    logic [CW:0]   inflight;
    logic [CW-1:0] drop_redir;
    logic [CW-1:0] drop_next;
    logic [63:0]   redir_pc;

    wire unused_redir_lsb = &{1'b0, redirect_pc[1:0]};

    assign inflight   = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = (state == RUN) && (inflight < CAP);
    assign mem_req_addr  = fetch_pc;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign redir    = redirect_valid && (state != IDLE);
    assign rsp_drop = mem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = mem_rsp_valid && (drop_cnt == '0);
    assign enq      = rsp_keep && !redir;
    assign deq      = instr_valid && instr_ready && !redir;
    assign redir_pc = {redirect_pc[63:2], 2'b00};

    // Everything still in flight (already-doomed or live) becomes doomed.
    assign drop_redir = drop_cnt + outstanding
                      + CW'(req_fire) - CW'(mem_rsp_valid);
    assign drop_next  = drop_cnt - CW'(rsp_drop);

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redir) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_redir;
            fetch_pc    <= redir_pc;
            rsp_pc      <= redir_pc;
            state       <= (drop_redir != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 64'd4;
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + 64'd4;
            end
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            count       <= count + CW'(enq) - CW'(deq);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
            drop_cnt    <= drop_next;
            case (state)
                IDLE:    state <= RUN;
                FLUSH:   if (drop_next == '0) state <= RUN;
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wr_ptr] <= mem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((state != IDLE) && !instr_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redir)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    // The credit rule keeps a full queue from ever seeing a lone enqueue.
    assert property (@(posedge clk) disable iff (!reset)
        !(enq && !deq && (count == FULL)));

endmodule
